// File: rtl/prev_value_write_sched.sv
// Write/fetch scheduler for the FAST template/previous-value store: round-robin
// serialization of lane replace requests and drain-before-fetch message sequencing.
module prev_value_write_sched #(
    parameter int unsigned BEAT_WIDTH       = 64,
    parameter int unsigned NUM_TEMPLATES    = 4,
    parameter int unsigned SUP_PATHS        = 4,
    parameter int unsigned MAX_MESSAGE_SIZE = 10,
    localparam int unsigned TW = (NUM_TEMPLATES > 1) ? $clog2(NUM_TEMPLATES) : 1,
    localparam int unsigned IW = (MAX_MESSAGE_SIZE > 1) ? $clog2(MAX_MESSAGE_SIZE) : 1
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [SUP_PATHS-1:0]                 req_valid,
    output logic [SUP_PATHS-1:0]                 req_ready,
    input  logic [SUP_PATHS-1:0][TW-1:0]         req_tid,
    input  logic [SUP_PATHS-1:0][IW-1:0]         req_idx,
    input  logic [SUP_PATHS-1:0][BEAT_WIDTH-1:0] req_data,
    input  logic                                 msg_start,
    input  logic [TW-1:0]                        msg_tid,
    output logic                                 msg_ack,
    output logic                                 wr_en,
    output logic [TW-1:0]                        wr_tid,
    output logic [IW-1:0]                        wr_idx,
    output logic [BEAT_WIDTH-1:0]                wr_data,
    output logic                                 fetch_en,
    output logic [TW-1:0]                        fetch_tid,
    output logic                                 busy,
    output logic                                 err_range
);

    localparam int unsigned PW = (SUP_PATHS > 1) ? $clog2(SUP_PATHS) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StDrain = 2'd1;
    localparam logic [1:0] StFetch = 2'd2;

    logic [1:0]                          state_q, state_d;
    logic [SUP_PATHS-1:0]                full_q, full_d;
    logic [SUP_PATHS-1:0][TW-1:0]        buf_tid_q, buf_tid_d;
    logic [SUP_PATHS-1:0][IW-1:0]        buf_idx_q, buf_idx_d;
    logic [SUP_PATHS-1:0][BEAT_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [PW-1:0]                       rr_ptr_q, rr_ptr_d;
    logic                                wr_en_q, wr_en_d;
    logic [TW-1:0]                       wr_tid_q, wr_tid_d;
    logic [IW-1:0]                       wr_idx_q, wr_idx_d;
    logic [BEAT_WIDTH-1:0]               wr_data_q, wr_data_d;
    logic                                fetch_en_q, fetch_en_d;
    logic [TW-1:0]                       fetch_tid_q, fetch_tid_d;
    logic                                msg_ack_q, msg_ack_d;
    logic [TW-1:0]                       last_tid_q, last_tid_d;
    logic                                last_valid_q, last_valid_d;
    logic                                dirty_q, dirty_d;
    logic                                err_q, err_d;

    logic [SUP_PATHS-1:0] grant;
    logic [PW-1:0]        grant_idx;
    logic                 grant_any;
    logic [PW-1:0]        sel;
    logic [SUP_PATHS-1:0] in_range;
    logic [SUP_PATHS-1:0] accept;
    logic                 fetch_hit;

    // First full buffer at or after the round-robin pointer wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sel       = '0;
        for (int k = 0; k < int'(SUP_PATHS); k++) begin
            sel = PW'((32'(rr_ptr_q) + 32'(k)) % SUP_PATHS);
            if (!grant_any && full_q[sel]) begin
                grant[sel] = 1'b1;
                grant_idx  = sel;
                grant_any  = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(SUP_PATHS); i++) begin
            in_range[i]  = (32'(req_idx[i]) < MAX_MESSAGE_SIZE) &&
                           (32'(req_tid[i]) < NUM_TEMPLATES);
            req_ready[i] = (state_q == StIdle) && (!full_q[i] || grant[i]);
        end
    end

    assign accept = req_valid & req_ready;

    // A buffer being granted this cycle can be refilled in the same cycle.
    always_comb begin
        full_d     = full_q & ~grant;
        buf_tid_d  = buf_tid_q;
        buf_idx_d  = buf_idx_q;
        buf_data_d = buf_data_q;
        for (int i = 0; i < int'(SUP_PATHS); i++) begin
            if (accept[i] && in_range[i]) begin
                full_d[i]     = 1'b1;
                buf_tid_d[i]  = req_tid[i];
                buf_idx_d[i]  = req_idx[i];
                buf_data_d[i] = req_data[i];
            end
        end
        err_d = err_q | (|(accept & ~in_range));
    end

    always_comb begin
        wr_en_d   = grant_any;
        wr_tid_d  = wr_tid_q;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        rr_ptr_d  = rr_ptr_q;
        if (grant_any) begin
            wr_tid_d  = buf_tid_q[grant_idx];
            wr_idx_d  = buf_idx_q[grant_idx];
            wr_data_d = buf_data_q[grant_idx];
            rr_ptr_d  = PW'((32'(grant_idx) + 32'd1) % SUP_PATHS);
        end
    end

    assign fetch_hit = last_valid_q && (msg_tid == last_tid_q) && !dirty_q;

    // Fetch outputs are registered on the DRAIN->FETCH edge so they are high during FETCH.
    always_comb begin
        state_d      = state_q;
        fetch_en_d   = 1'b0;
        msg_ack_d    = 1'b0;
        fetch_tid_d  = fetch_tid_q;
        last_tid_d   = last_tid_q;
        last_valid_d = last_valid_q;
        dirty_d      = dirty_q | (wr_en_q && (wr_tid_q == last_tid_q));
        case (state_q)
            StIdle: begin
                if (msg_start) state_d = StDrain;
            end
            StDrain: begin
                if (!(|full_q) && !wr_en_q) begin
                    state_d   = StFetch;
                    msg_ack_d = 1'b1;
                    if (!fetch_hit) begin
                        fetch_en_d   = 1'b1;
                        fetch_tid_d  = msg_tid;
                        last_tid_d   = msg_tid;
                        last_valid_d = 1'b1;
                        dirty_d      = 1'b0;
                    end
                end
            end
            StFetch: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            full_q       <= '0;
            buf_tid_q    <= '0;
            buf_idx_q    <= '0;
            buf_data_q   <= '0;
            rr_ptr_q     <= '0;
            wr_en_q      <= 1'b0;
            wr_tid_q     <= '0;
            wr_idx_q     <= '0;
            wr_data_q    <= '0;
            fetch_en_q   <= 1'b0;
            fetch_tid_q  <= '0;
            msg_ack_q    <= 1'b0;
            last_tid_q   <= '0;
            last_valid_q <= 1'b0;
            dirty_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            buf_tid_q    <= buf_tid_d;
            buf_idx_q    <= buf_idx_d;
            buf_data_q   <= buf_data_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_en_q      <= wr_en_d;
            wr_tid_q     <= wr_tid_d;
            wr_idx_q     <= wr_idx_d;
            wr_data_q    <= wr_data_d;
            fetch_en_q   <= fetch_en_d;
            fetch_tid_q  <= fetch_tid_d;
            msg_ack_q    <= msg_ack_d;
            last_tid_q   <= last_tid_d;
            last_valid_q <= last_valid_d;
            dirty_q      <= dirty_d;
            err_q        <= err_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_tid    = wr_tid_q;
    assign wr_idx    = wr_idx_q;
    assign wr_data   = wr_data_q;
    assign fetch_en  = fetch_en_q;
    assign fetch_tid = fetch_tid_q;
    assign msg_ack   = msg_ack_q;
    assign err_range = err_q;
    assign busy      = (|full_q) || wr_en_q || (state_q != StIdle);

endmodule

// File: tb/tb_prev_value_write_sched.sv
// Bench for prev_value_write_sched: directed scenarios plus randomized traffic scored
// against a per-lane-ordered pending-request list and a last-fetched-template model.
module tb_prev_value_write_sched;

    localparam int BW  = 64;
    localparam int NT  = 4;
    localparam int SP  = 4;
    localparam int MMS = 10;
    localparam int TW  = 2;
    localparam int IW  = 4;

    typedef struct packed {
        logic [1:0]    lane;
        logic [TW-1:0] tid;
        logic [IW-1:0] idx;
        logic [BW-1:0] data;
    } ent_t;

    typedef struct packed {
        logic [31:0] cyc;
        ent_t        e;
    } log_t;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic [SP-1:0]          req_valid = '0;
    logic [SP-1:0]          req_ready;
    logic [SP-1:0][TW-1:0]  req_tid = '0;
    logic [SP-1:0][IW-1:0]  req_idx = '0;
    logic [SP-1:0][BW-1:0]  req_data = '0;
    logic                   msg_start = 1'b0;
    logic [TW-1:0]          msg_tid = '0;
    logic                   msg_ack;
    logic                   wr_en;
    logic [TW-1:0]          wr_tid;
    logic [IW-1:0]          wr_idx;
    logic [BW-1:0]          wr_data;
    logic                   fetch_en;
    logic [TW-1:0]          fetch_tid;
    logic                   busy;
    logic                   err_range;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ent_t exp_q[$];
    log_t wlog[$];

    // Reference state: last fetched template, dirty since then, sticky range error.
    logic          lv_m = 1'b0;
    logic          dirty_m = 1'b0;
    logic [TW-1:0] lt_m = '0;
    logic          err_m = 1'b0;
    logic          ack_seen = 1'b0;

    int    m_pos;
    logic  m_ordered;
    logic  m_exp_fetch;
    log_t  m_l;
    ent_t  m_e;

    prev_value_write_sched #(
        .BEAT_WIDTH      (BW),
        .NUM_TEMPLATES   (NT),
        .SUP_PATHS       (SP),
        .MAX_MESSAGE_SIZE(MMS)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_tid  (req_tid),
        .req_idx  (req_idx),
        .req_data (req_data),
        .msg_start(msg_start),
        .msg_tid  (msg_tid),
        .msg_ack  (msg_ack),
        .wr_en    (wr_en),
        .wr_tid   (wr_tid),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .fetch_en (fetch_en),
        .fetch_tid(fetch_tid),
        .busy     (busy),
        .err_range(err_range)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every write must match a pending accepted request, in per-lane order.
    always @(negedge clk) begin
        if (rstn) begin
            checks++;
            if (err_range !== err_m) begin
                errors++;
                $display("FAIL err_range: got %b want %b", err_range, err_m);
            end
            if (wr_en === 1'b1) begin
                m_pos = -1;
                for (int k = 0; k < exp_q.size(); k++)
                    if (m_pos < 0 && exp_q[k].tid == wr_tid && exp_q[k].idx == wr_idx &&
                        exp_q[k].data == wr_data) m_pos = k;
                m_l.cyc = cyc;
                m_l.e.lane = 2'd0;
                m_l.e.tid = wr_tid;
                m_l.e.idx = wr_idx;
                m_l.e.data = wr_data;
                checks++;
                if (m_pos < 0) begin
                    errors++;
                    $display("FAIL write_match: got tid=%0d idx=%0d data=%h, want a pending request",
                             wr_tid, wr_idx, wr_data);
                end else begin
                    m_ordered = 1'b1;
                    for (int k = 0; k < m_pos; k++)
                        if (exp_q[k].lane == exp_q[m_pos].lane) m_ordered = 1'b0;
                    m_l.e.lane = exp_q[m_pos].lane;
                    checks++;
                    if (!m_ordered) begin
                        errors++;
                        $display("FAIL write_order: lane %0d data=%h overtook older request",
                                 exp_q[m_pos].lane, wr_data);
                    end
                    exp_q.delete(m_pos);
                end
                wlog.push_back(m_l);
                if (wr_tid == lt_m) dirty_m = 1'b1;
            end
            if (msg_ack === 1'b1) begin
                m_exp_fetch = !(lv_m && msg_tid == lt_m && !dirty_m);
                checks++;
                if (fetch_en !== m_exp_fetch) begin
                    errors++;
                    $display("FAIL fetch_en: got %b want %b (tid %0d)", fetch_en, m_exp_fetch, msg_tid);
                end
                if (m_exp_fetch) begin
                    checks++;
                    if (fetch_tid !== msg_tid) begin
                        errors++;
                        $display("FAIL fetch_tid: got %0d want %0d", fetch_tid, msg_tid);
                    end
                    lt_m = msg_tid;
                    lv_m = 1'b1;
                    dirty_m = 1'b0;
                end
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL fetch_order: got %0d pending writes at ack want 0", exp_q.size());
                end
                ack_seen = 1'b1;
            end else begin
                checks++;
                if (fetch_en !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_spurious: got fetch_en=%b want 0 without msg_ack", fetch_en);
                end
            end
            for (int i = 0; i < SP; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (int'(req_idx[i]) < MMS && int'(req_tid[i]) < NT) begin
                        m_e.lane = 2'(i);
                        m_e.tid = req_tid[i];
                        m_e.idx = req_idx[i];
                        m_e.data = req_data[i];
                        exp_q.push_back(m_e);
                    end else begin
                        err_m = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic drive(input int lane, input int tid, input int idx, input logic [BW-1:0] d);
        req_valid[lane] = 1'b1;
        req_tid[lane] = TW'(tid);
        req_idx[lane] = IW'(idx);
        req_data[lane] = d;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy !== 1'b0 || exp_q.size() != 0) && n < 300);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got busy=%b pending=%0d want busy=0 pending=0", busy, exp_q.size());
        end
    endtask

    task automatic wait_ack(output logic f, output logic [TW-1:0] t, output int ac);
        int n = 0;
        f = 1'b0;
        t = '0;
        ac = 0;
        while (!ack_seen && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!ack_seen) begin
            errors++;
            $display("FAIL msg_ack_timeout: got no msg_ack want one within 300 cycles");
        end else begin
            f = fetch_en;
            t = fetch_tid;
            ac = cyc;
        end
        @(posedge clk);
        #1;
        msg_start = 1'b0;
    endtask

    task automatic do_msg(input int tid, output logic f, output logic [TW-1:0] t);
        int ac;
        @(posedge clk);
        #1;
        msg_tid = TW'(tid);
        ack_seen = 1'b0;
        msg_start = 1'b1;
        wait_ack(f, t, ac);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn = 1'b0;
        req_valid = '0;
        msg_start = 1'b0;
        exp_q.delete();
        lv_m = 1'b0;
        dirty_m = 1'b0;
        lt_m = '0;
        err_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        wlog.delete();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wr_en, wr_tid, wr_idx, wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_wr: got en=%b tid=%0d idx=%0d data=%h want all 0",
                     wr_en, wr_tid, wr_idx, wr_data);
        end
        checks++;
        if ({fetch_en, fetch_tid, msg_ack} !== '0) begin
            errors++;
            $display("FAIL reset_fetch: got fetch_en=%b tid=%0d ack=%b want 0", fetch_en, fetch_tid, msg_ack);
        end
        checks++;
        if ({err_range, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got err=%b busy=%b want 0 0", err_range, busy);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'hF || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got ready=%b busy=%b want 1111 0", req_ready, busy);
        end
    endtask

    task automatic test_single();
        int hs;
        wlog.delete();
        @(posedge clk);
        #1;
        drive(2, 1, 3, 64'hDEAD);
        @(posedge clk);
        #1;
        hs = cyc;
        req_valid = '0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'hF) begin
                errors++;
                $display("FAIL single_ready: got %b want 1111", req_ready);
            end
        end
        wait_idle();
        checks++;
        if (wlog.size() != 1) begin
            errors++;
            $display("FAIL single_count: got %0d writes want 1", wlog.size());
        end else begin
            checks++;
            if (int'(wlog[0].cyc) != hs + 1 || wlog[0].e.tid != 1 || wlog[0].e.idx != 3 ||
                wlog[0].e.data != 64'hDEAD) begin
                errors++;
                $display("FAIL single_write: got cyc=%0d tid=%0d idx=%0d data=%h want cyc=%0d 1 3 dead",
                         wlog[0].cyc, wlog[0].e.tid, wlog[0].e.idx, wlog[0].e.data, hs + 1);
            end
        end
    endtask

    task automatic rr_burst(input logic [3:0] lanes, input logic [BW-1:0] base,
                            input int n_exp, input int o0, input int o1, input int o2, input int o3);
        int hs;
        int ord[4];
        ord = '{o0, o1, o2, o3};
        wlog.delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < SP; i++) if (lanes[i]) drive(i, i, i + 4, base + BW'(i));
        @(posedge clk);
        #1;
        hs = cyc;
        req_valid = '0;
        wait_idle();
        checks++;
        if (wlog.size() != n_exp) begin
            errors++;
            $display("FAIL rr_count: got %0d writes want %0d", wlog.size(), n_exp);
        end else begin
            for (int k = 0; k < n_exp; k++) begin
                checks++;
                if (wlog[k].e.data != base + BW'(ord[k]) || int'(wlog[k].cyc) != hs + 1 + k) begin
                    errors++;
                    $display("FAIL rr_order: slot %0d got data=%h cyc=%0d want data=%h cyc=%0d",
                             k, wlog[k].e.data, wlog[k].cyc, base + BW'(ord[k]), hs + 1 + k);
                end
            end
        end
    endtask

    task automatic test_rr();
        do_reset();
        rr_burst(4'b1111, 64'hA0, 4, 0, 1, 2, 3);
        rr_burst(4'b1010, 64'hB0, 2, 1, 3, 0, 0);
        rr_burst(4'b1001, 64'hC0, 2, 0, 3, 0, 0);
    endtask

    task automatic test_back_to_back();
        int hs = 0;
        wlog.delete();
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) hs = cyc;
            drive(0, n % 4, n, 64'h100 + BW'(n));
            @(negedge clk);
            checks++;
            if (req_ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready: beat %0d got ready=%b want 1", n, req_ready[0]);
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();
        checks++;
        if (wlog.size() != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d writes want 8", wlog.size());
        end else begin
            for (int n = 0; n < 8; n++) begin
                checks++;
                if (wlog[n].e.data != 64'h100 + BW'(n) || int'(wlog[n].cyc) != hs + 1 + n) begin
                    errors++;
                    $display("FAIL b2b_write: beat %0d got data=%h cyc=%0d want data=%h cyc=%0d",
                             n, wlog[n].e.data, wlog[n].cyc, 64'h100 + BW'(n), hs + 1 + n);
                end
            end
        end
    endtask

    task automatic test_msg_fetch();
        logic f;
        logic [TW-1:0] t;
        int ac;
        wlog.delete();
        @(posedge clk);
        #1;
        drive(0, 0, 1, 64'hD0);
        drive(1, 1, 2, 64'hD1);
        drive(2, 3, 4, 64'hD2);
        msg_tid = 2'd2;
        ack_seen = 1'b0;
        msg_start = 1'b1;
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'h0) begin
            errors++;
            $display("FAIL drain_ready: got %b want 0000", req_ready);
        end
        wait_ack(f, t, ac);
        checks++;
        if (f !== 1'b1 || t !== 2'd2) begin
            errors++;
            $display("FAIL msg_fetch: got fetch_en=%b tid=%0d want 1 2", f, t);
        end
        checks++;
        if (wlog.size() != 3 || int'(wlog[wlog.size() - 1].cyc) >= ac) begin
            errors++;
            $display("FAIL msg_drain: got %0d writes before ack want 3", wlog.size());
        end
        @(negedge clk);
        checks++;
        if (msg_ack !== 1'b0 || req_ready !== 4'hF || busy !== 1'b0) begin
            errors++;
            $display("FAIL msg_return: got ack=%b ready=%b busy=%b want 0 1111 0", msg_ack, req_ready, busy);
        end
    endtask

    task automatic test_msg_hit();
        logic f;
        logic [TW-1:0] t;
        do_msg(2, f, t);
        checks++;
        if (f !== 1'b0) begin
            errors++;
            $display("FAIL msg_hit: got fetch_en=%b want 0", f);
        end
        @(posedge clk);
        #1;
        drive(1, 2, 5, 64'hE1);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();
        do_msg(2, f, t);
        checks++;
        if (f !== 1'b1 || t !== 2'd2) begin
            errors++;
            $display("FAIL msg_dirty: got fetch_en=%b tid=%0d want 1 2", f, t);
        end
        do_msg(1, f, t);
        checks++;
        if (f !== 1'b1 || t !== 2'd1) begin
            errors++;
            $display("FAIL msg_new_tid: got fetch_en=%b tid=%0d want 1 1", f, t);
        end
    endtask

    task automatic test_range_reset();
        wlog.delete();
        @(posedge clk);
        #1;
        drive(3, 0, 12, 64'hF3);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (5) @(negedge clk);
        checks++;
        if (wlog.size() != 0 || err_range !== 1'b1) begin
            errors++;
            $display("FAIL range: got writes=%0d err=%b want 0 1", wlog.size(), err_range);
        end
        @(posedge clk);
        #1;
        drive(0, 1, 1, 64'h51);
        drive(1, 2, 2, 64'h52);
        @(posedge clk);
        #1;
        req_valid = '0;
        rstn = 1'b0;
        #1;
        checks++;
        if ({wr_en, wr_data, busy, err_range, msg_ack, fetch_en} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got wr_en=%b data=%h busy=%b err=%b want all 0",
                     wr_en, wr_data, busy, err_range);
        end
        exp_q.delete();
        lv_m = 1'b0;
        dirty_m = 1'b0;
        lt_m = '0;
        err_m = 1'b0;
        @(posedge clk);
        #1;
        wlog.delete();
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (wlog.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_drop: got writes=%0d busy=%b want 0 0", wlog.size(), busy);
        end
    endtask

    task automatic test_random();
        logic f;
        logic [TW-1:0] t;
        int ac;
        for (int it = 0; it < 400; it++) begin
            @(posedge clk);
            #1;
            if (msg_start && ack_seen) begin
                msg_start = 1'b0;
            end else if (!msg_start && $urandom_range(0, 29) == 0) begin
                msg_tid = TW'($urandom_range(0, 1));
                ack_seen = 1'b0;
                msg_start = 1'b1;
            end
            for (int i = 0; i < SP; i++) begin
                req_valid[i] = ($urandom_range(0, 1) == 1);
                req_tid[i] = TW'($urandom_range(0, NT - 1));
                req_idx[i] = IW'($urandom_range(0, 11));
                req_data[i] = {$urandom, $urandom};
            end
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        if (msg_start) wait_ack(f, t, ac);
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_back_to_back();
        test_msg_fetch();
        test_msg_hit();
        test_range_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
